// File: rtl/spi_mem_bridge.sv
// SPI (mode 0) slave to DFF-memory bridge.
// Two-byte frames: a command byte (read flag, address) followed by a data byte
// that is either write data from mosi or read data shifted out on miso.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for a synchronised cs_n falling edge
//   CMD       | shifting in the command byte (rises 1..8)
//   WR_DATA   | shifting in the write data byte (rises 9..16)
//   WR_STROBE | single-cycle memory write (mem_lr_n=0, mem_ce_n=1)
//   RD_REQ    | first memory read cycle (mem_ce_n=0)
//   RD_WAIT   | second memory read cycle, read data loaded into shifter
//   RD_SHIFT  | driving read data on miso, shifting on sclk falls
//   DONE      | frame finished, extra sclk edges ignored until cs_n high
module spi_mem_bridge #(
  parameter int ADDR_W      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_lr_n,
  output logic              mem_ce_n,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    WR_STROBE,
    RD_REQ,
    RD_WAIT,
    RD_SHIFT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  logic              sclk_s;
  logic              mosi_s;
  logic              cs_n_int;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              cs_fall;
  logic [7:0]        shift;
  logic [3:0]        bit_cnt;
  logic [ADDR_W-1:0] addr_field;
  logic              cmd_read;

  // Synchronise the SPI pins and keep last-cycle copies for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_n_int;
    end
  end

  // A disabled bridge looks exactly like a deselected one.
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_n_int  = cs_sync[SYNC_STAGES-1] | ~ena;
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = cs_prev & ~cs_n_int;

  // On the 8th rise the 7 earlier bits sit in shift[6:0] and the last one is
  // still on mosi_s, so the command byte is {shift[6:0], mosi_s}.
  assign cmd_read   = shift[6];
  assign addr_field = {shift[ADDR_W-2:0], mosi_s};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and memory/miso control decode.
  always_comb begin
    state_nxt = state;
    mem_lr_n  = 1'b1;
    mem_ce_n  = 1'b1;
    miso_oe   = 1'b0;
    miso      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (cs_fall) state_nxt = CMD;
      end
      CMD: begin
        if (cs_n_int) begin
          state_nxt = IDLE;
        end else if (sclk_rise && bit_cnt == 4'd7) begin
          state_nxt = cmd_read ? RD_REQ : WR_DATA;
        end
      end
      WR_DATA: begin
        if (cs_n_int) begin
          state_nxt = IDLE;
        end else if (sclk_rise && bit_cnt == 4'd15) begin
          state_nxt = WR_STROBE;
        end
      end
      WR_STROBE: begin
        // A started strobe always completes; DONE then handles any abort.
        mem_lr_n  = 1'b0;
        state_nxt = DONE;
      end
      RD_REQ: begin
        mem_ce_n  = 1'b0;
        state_nxt = cs_n_int ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        mem_ce_n  = 1'b0;
        state_nxt = cs_n_int ? IDLE : RD_SHIFT;
      end
      RD_SHIFT: begin
        miso_oe = 1'b1;
        miso    = shift[7];
        if (cs_n_int) begin
          state_nxt = IDLE;
        end else if (sclk_rise && bit_cnt == 4'd15) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (cs_n_int) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter and latched memory address/data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift     <= '0;
      bit_cnt   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            shift   <= '0;
            bit_cnt <= '0;
          end
        end
        CMD: begin
          if (!cs_n_int && sclk_rise) begin
            shift   <= {shift[6:0], mosi_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) mem_addr <= addr_field;
          end
        end
        WR_DATA: begin
          if (!cs_n_int && sclk_rise) begin
            shift   <= {shift[6:0], mosi_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) mem_wdata <= {shift[6:0], mosi_s};
          end
        end
        RD_WAIT: begin
          if (!cs_n_int) shift <= mem_rdata;
        end
        RD_SHIFT: begin
          if (!cs_n_int) begin
            if (sclk_rise) bit_cnt <= bit_cnt + 4'd1;
            // The fall right after the 8th rise must keep bit 7 on miso; the
            // master samples it on the 9th rise.
            if (sclk_fall && bit_cnt > 4'd8) shift <= {shift[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Self-checking bench for spi_mem_bridge: an SPI master drives frames, a DFF
// memory model answers reads, and write/read scoreboards hold expectations.
module tb_spi_mem_bridge;

  localparam int ADDR_W = 6;
  localparam int SYNC   = 2;
  localparam int HALF   = 80;  // sclk half period: sclk = clk/16

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_lr_n;
  logic              mem_ce_n;
  logic [7:0]        mem_rdata;
  logic              busy;

  spi_mem_bridge #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_lr_n  (mem_lr_n),
    .mem_ce_n  (mem_ce_n),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem     [64];
  logic [7:0]  exp_mem [64];
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  int wr_pushed = 0;
  int ce_cnt = 0;

  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Memory model and write scoreboard: each strobe pops one expected write.
  always @(negedge clk) begin
    if (mem_ce_n == 1'b0) ce_cnt++;
    if (mem_lr_n == 1'b0) begin
      strobe_cnt++;
      chk("strobe_count", strobe_cnt, wr_pushed);
      chk("strobe_ce_n", mem_ce_n, 1);
      if (wr_q.size() > 0) begin
        logic [15:0] e;
        e = wr_q.pop_front();
        chk("wr_addr", mem_addr, e[15:8]);
        chk("wr_data", mem_wdata, e[7:0]);
      end
      mem[mem_addr] = mem_wdata;
    end
  end

  task automatic spi_bits(input logic [23:0] d, input int nbits, input bit rd,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[23-i];
      #HALF;
      sclk = 1'b1;
      if (rd && i >= 8 && i < 16) begin
        rx = {rx[6:0], miso};
        chk("miso_oe", miso_oe, 1);
      end
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_start;
    cs_n = 1'b0;
    #HALF;
  endtask

  // Deassert, then hold cs_n high for one full sclk period.
  task automatic cs_end;
    #HALF;
    cs_n = 1'b1;
    #(2*HALF);
    chk("idle_after_frame", busy, 0);
  endtask

  task automatic wr_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits);
    logic [7:0] rx;
    logic [ADDR_W-1:0] a;
    a = b0[ADDR_W-1:0];
    wr_q.push_back({2'b00, a, b1});
    wr_pushed++;
    exp_mem[a] = b1;
    cs_start();
    spi_bits({b0, b1, 8'hFF}, nbits, 1'b0, rx);
    cs_end();
  endtask

  task automatic rd_frame(input logic [7:0] b0);
    logic [7:0] rx;
    int ce0;
    rd_q.push_back(exp_mem[b0[ADDR_W-1:0]]);
    ce0 = ce_cnt;
    cs_start();
    spi_bits({b0, 8'h00, 8'h00}, 16, 1'b1, rx);
    cs_end();
    chk("rd_data", rx, rd_q.pop_front());
    chk("ce_low_cycles", ce_cnt - ce0, 2);
  endtask

  task automatic chk_reset_vals;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_lr_n", mem_lr_n, 1);
    chk("rst_mem_ce_n", mem_ce_n, 1);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] rx;
    int s0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 8'h00;
      exp_mem[i] = 8'h00;
    end
    rst_n = 1'b0;
    ena   = 1'b1;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic write and read-back, command bit 6 ignored on read.
    wr_frame(8'h01, 8'hAA, 16);
    rd_frame(8'h81);
    rd_frame(8'hC1);

    // Address boundaries.
    wr_frame(8'h3F, 8'h5A, 16);
    rd_frame(8'hBF);
    wr_frame(8'h00, 8'h5C, 16);
    rd_frame(8'h80);
    wr_frame(8'h47, 8'h99, 16);
    rd_frame(8'h87);

    // Back-to-back writes.
    wr_frame(8'h02, 8'h11, 16);
    wr_frame(8'h03, 8'h22, 16);
    rd_frame(8'h82);
    rd_frame(8'h83);

    // Extra sclk edges after a complete write frame.
    wr_frame(8'h08, 8'h44, 24);
    rd_frame(8'h88);

    // Abort by cs_n after 10 bits.
    s0 = strobe_cnt;
    cs_start();
    spi_bits({8'h05, 8'h55, 8'h00}, 10, 1'b0, rx);
    chk("abort_busy_before", busy, 1);
    cs_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    chk("abort_busy_after", busy, 0);
    #(2*HALF);
    chk("abort_no_strobe", strobe_cnt, s0);
    rd_frame(8'h85);

    // Abort by ena after 12 bits.
    s0 = strobe_cnt;
    cs_start();
    spi_bits({8'h09, 8'h66, 8'h00}, 12, 1'b0, rx);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    chk("ena_abort_busy", busy, 0);
    cs_n = 1'b1;
    ena  = 1'b1;
    #(2*HALF);
    chk("ena_abort_no_strobe", strobe_cnt, s0);

    // Reset in the middle of a frame.
    s0 = strobe_cnt;
    cs_start();
    spi_bits({8'h06, 8'h77, 8'h00}, 12, 1'b0, rx);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    cs_n  = 1'b1;
    #(4*HALF);
    chk("reset_no_strobe", strobe_cnt, s0);
    chk("reset_idle", busy, 0);
    wr_frame(8'h04, 8'h33, 16);
    rd_frame(8'h84);

    #(2*HALF);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("strobe_total", strobe_cnt, wr_pushed);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
